// File: rtl/protocol_err_pkg.sv
// Shared types and constants for the AFU TX protocol-error controller.
// The error index map is fixed here so CSR decode and the checker agree on bit positions.
package protocol_err_pkg;

    localparam int NUM_ERR_DEFAULT = 10;

    localparam int ERR_MALFORMED    = 0;
    localparam int ERR_MAX_PLD      = 1;
    localparam int ERR_MAX_RDREQ    = 2;
    localparam int ERR_MWR_INSUFF   = 3;
    localparam int ERR_MWR_OVERRUN  = 4;
    localparam int ERR_MMIO_INSUFF  = 5;
    localparam int ERR_MMIO_OVERRUN = 6;
    localparam int ERR_MAX_TAG      = 7;
    localparam int ERR_MMIO_RD_RST  = 8;
    localparam int ERR_MMIO_WR_RST  = 9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_BLOCKED  = 2'd2,
        ST_WAIT_RST = 2'd3
    } err_state_e;

    // Isolate the lowest set bit (two's-complement trick); callers zero-extend up to 32 bits.
    function automatic logic [31:0] first_one(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/protocol_err_ctrl_tx_pkt_tracker.sv
// Tracks whether the AFU TX stream is inside a multi-beat packet.
// Produces the registered in-packet flag plus accepted sop/eop strobes.
module tx_pkt_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_valid,
    input  logic tx_sop,
    input  logic tx_eop,
    input  logic tx_ready,
    output logic in_pkt,
    output logic sop_acc,
    output logic eop_acc
);

    logic beat_acc;

    assign beat_acc = tx_valid & tx_ready;
    assign sop_acc  = beat_acc & tx_sop;
    assign eop_acc  = beat_acc & tx_eop;

    // eop has priority so a single-beat packet never leaves in_pkt set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            in_pkt <= 1'b0;
        else if (eop_acc)
            in_pkt <= 1'b0;
        else if (sop_acc)
            in_pkt <= 1'b1;
    end

endmodule

// File: rtl/protocol_err_ctrl.sv
// Error-response controller: captures first-error context and walks the port through
// drain, block and recovery so no AFU TX traffic escapes until SW clear + soft reset.
module protocol_err_ctrl
    import protocol_err_pkg::*;
#(
    parameter int NUM_ERR = NUM_ERR_DEFAULT,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_ERR-1:0] i_err_vec,
    input  logic [10:0]        i_err_vf_num,
    input  logic               i_tx_valid,
    input  logic               i_tx_sop,
    input  logic               i_tx_eop,
    input  logic               i_tx_ready,
    input  logic               i_sw_clear,
    input  logic               i_afu_softreset,
    output logic [NUM_ERR-1:0] o_err_status,
    output logic [NUM_ERR-1:0] o_first_err,
    output logic [10:0]        o_err_vf_num,
    output logic [TS_W-1:0]    o_err_ts,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic               o_err_valid,
    output logic               o_intr,
    output logic               o_block_tx,
    output logic               o_drop_tx,
    output logic [1:0]         o_state
);

    err_state_e         state, state_nxt;
    logic [TS_W-1:0]    ts;
    logic               clr_req;
    logic               in_pkt, sop_acc, eop_acc;
    logic               any_err;
    logic               capture, idle_clear, exit_rst;
    logic [NUM_ERR-1:0] first_oh;

    tx_pkt_tracker u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (i_tx_valid),
        .tx_sop   (i_tx_sop),
        .tx_eop   (i_tx_eop),
        .tx_ready (i_tx_ready),
        .in_pkt   (in_pkt),
        .sop_acc  (sop_acc),
        .eop_acc  (eop_acc)
    );

    assign any_err    = |i_err_vec;
    assign first_oh   = NUM_ERR'(first_one(32'(i_err_vec)));
    assign capture    = (state == ST_IDLE) & any_err;
    assign idle_clear = (state == ST_IDLE) & i_sw_clear & ~any_err;
    assign exit_rst   = (state == ST_WAIT_RST) & ~i_afu_softreset & (clr_req | i_sw_clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // A packet opened by this very beat still needs draining unless it also ends here.
                if (any_err)
                    state_nxt = ((in_pkt | sop_acc) & ~eop_acc) ? ST_DRAIN : ST_BLOCKED;
            end
            ST_DRAIN:    if (eop_acc)         state_nxt = ST_BLOCKED;
            ST_BLOCKED:  if (i_afu_softreset) state_nxt = ST_WAIT_RST;
            ST_WAIT_RST: if (exit_rst)        state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    assign o_block_tx = (state != ST_IDLE);
    assign o_drop_tx  = (state == ST_DRAIN);
    assign o_state    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ts <= '0;
        else
            ts <= ts + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clr_req <= 1'b0;
        else if (exit_rst)
            clr_req <= 1'b0;
        else if (i_sw_clear && (state == ST_BLOCKED || state == ST_WAIT_RST))
            clr_req <= 1'b1;
    end

    // Status and counter: an error landing in a clear cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err_status <= '0;
            o_err_cnt    <= '0;
        end else if (exit_rst || idle_clear) begin
            o_err_status <= i_err_vec;
            o_err_cnt    <= any_err ? CNT_W'(1) : '0;
        end else begin
            o_err_status <= o_err_status | i_err_vec;
            if (any_err && o_err_cnt != '1)
                o_err_cnt <= o_err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_first_err  <= '0;
            o_err_vf_num <= '0;
            o_err_ts     <= '0;
            o_err_valid  <= 1'b0;
            o_intr       <= 1'b0;
        end else begin
            o_intr <= capture;
            if (capture) begin
                o_first_err  <= first_oh;
                o_err_vf_num <= i_err_vf_num;
                o_err_ts     <= ts;
                o_err_valid  <= 1'b1;
            end else if (exit_rst) begin
                o_first_err <= '0;
                o_err_valid <= 1'b0;
            end else if (idle_clear) begin
                o_err_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_protocol_err_ctrl.sv
// Directed bench for protocol_err_ctrl: first-error capture, drain/block/recovery
// sequencing, saturation and asynchronous reset, with hand-computed expectations.
module tb_protocol_err_ctrl;

    localparam int NUM_ERR = 10;
    localparam int TS_W    = 32;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_ERR-1:0] i_err_vec;
    logic [10:0]        i_err_vf_num;
    logic               i_tx_valid, i_tx_sop, i_tx_eop, i_tx_ready;
    logic               i_sw_clear, i_afu_softreset;
    logic [NUM_ERR-1:0] o_err_status, o_first_err;
    logic [10:0]        o_err_vf_num;
    logic [TS_W-1:0]    o_err_ts;
    logic [CNT_W-1:0]   o_err_cnt;
    logic               o_err_valid, o_intr, o_block_tx, o_drop_tx;
    logic [1:0]         o_state;

    int total = 0;
    int bad   = 0;
    logic [TS_W-1:0] tb_ts;
    logic [TS_W-1:0] exp_ts;

    protocol_err_ctrl #(.NUM_ERR(NUM_ERR), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_err_vec      (i_err_vec),
        .i_err_vf_num   (i_err_vf_num),
        .i_tx_valid     (i_tx_valid),
        .i_tx_sop       (i_tx_sop),
        .i_tx_eop       (i_tx_eop),
        .i_tx_ready     (i_tx_ready),
        .i_sw_clear     (i_sw_clear),
        .i_afu_softreset(i_afu_softreset),
        .o_err_status   (o_err_status),
        .o_first_err    (o_first_err),
        .o_err_vf_num   (o_err_vf_num),
        .o_err_ts       (o_err_ts),
        .o_err_cnt      (o_err_cnt),
        .o_err_valid    (o_err_valid),
        .o_intr         (o_intr),
        .o_block_tx     (o_block_tx),
        .o_drop_tx      (o_drop_tx),
        .o_state        (o_state)
    );

    always #5 clk = ~clk;

    // Reference cycle count: the value the timestamp should hold in any given cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic r);
        i_tx_valid = v; i_tx_sop = s; i_tx_eop = e; i_tx_ready = r;
    endtask

    // From BLOCKED: clear request, soft reset pulse, back to IDLE.
    task automatic recover;
        i_sw_clear = 1'b1; tick; i_sw_clear = 1'b0;
        i_afu_softreset = 1'b1; tick;
        i_afu_softreset = 1'b0; tick;
    endtask

    initial begin
        rst_n = 1'b0;
        i_err_vec = '0; i_err_vf_num = '0;
        beat(0, 0, 0, 0);
        i_sw_clear = 1'b0; i_afu_softreset = 1'b0;
        tick; tick;
        chk("rst_state",  64'(o_state), 64'd0);
        chk("rst_block",  64'(o_block_tx), 64'd0);
        chk("rst_status", 64'(o_err_status), 64'd0);
        chk("rst_cnt",    64'(o_err_cnt), 64'd0);
        chk("rst_valid",  64'(o_err_valid), 64'd0);
        rst_n = 1'b1;
        tick; tick;

        // 1: error 0x080 on a single-beat packet
        i_err_vec = 10'h080; i_err_vf_num = 11'd5; beat(1, 1, 1, 1);
        exp_ts = tb_ts;
        tick;
        i_err_vec = '0; i_err_vf_num = '0; beat(0, 0, 0, 0);
        chk("t1_first", 64'(o_first_err), 64'h080);
        chk("t1_vf",    64'(o_err_vf_num), 64'd5);
        chk("t1_ts",    64'(o_err_ts), 64'(exp_ts));
        chk("t1_intr",  64'(o_intr), 64'd1);
        chk("t1_state", 64'(o_state), 64'd2);
        chk("t1_block", 64'(o_block_tx), 64'd1);
        chk("t1_valid", 64'(o_err_valid), 64'd1);
        tick;
        chk("t1_intr_w1", 64'(o_intr), 64'd0);

        // 4: clear before soft reset, soft reset held 10 cycles
        i_sw_clear = 1'b1; tick; i_sw_clear = 1'b0;
        i_afu_softreset = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        chk("t4_wait", 64'(o_state), 64'd3);
        chk("t4_block_wait", 64'(o_block_tx), 64'd1);
        i_afu_softreset = 1'b0; tick;
        chk("t4_idle",   64'(o_state), 64'd0);
        chk("t4_block",  64'(o_block_tx), 64'd0);
        chk("t4_status", 64'(o_err_status), 64'd0);
        chk("t4_first",  64'(o_first_err), 64'd0);
        chk("t4_valid",  64'(o_err_valid), 64'd0);
        chk("t4_cnt",    64'(o_err_cnt), 64'd0);

        // 2: error at beat 2 of a 4-beat packet
        beat(1, 1, 0, 1); tick;
        beat(1, 0, 0, 1); i_err_vec = 10'h002; tick;
        i_err_vec = '0;
        chk("t2_drain", 64'(o_state), 64'd1);
        chk("t2_drop3", 64'(o_drop_tx), 64'd1);
        chk("t2_first", 64'(o_first_err), 64'h002);
        tick;
        beat(1, 0, 1, 0); tick;
        chk("t2_drop4", 64'(o_drop_tx), 64'd1);
        chk("t2_stall", 64'(o_state), 64'd1);
        beat(1, 0, 1, 1); tick;
        beat(0, 0, 0, 0);
        chk("t2_blocked", 64'(o_state), 64'd2);
        chk("t2_nodrop",  64'(o_drop_tx), 64'd0);
        i_afu_softreset = 1'b1; tick;
        i_afu_softreset = 1'b0; i_sw_clear = 1'b1; tick;
        i_sw_clear = 1'b0;
        chk("t2_idle", 64'(o_state), 64'd0);

        // 3: simultaneous errors, later error held off first_err
        i_err_vec = 10'h018; tick;
        i_err_vec = '0;
        chk("t3_first",  64'(o_first_err), 64'h008);
        chk("t3_status", 64'(o_err_status), 64'h018);
        tick;
        i_err_vec = 10'h001; tick;
        i_err_vec = '0;
        chk("t3_status2", 64'(o_err_status), 64'h019);
        chk("t3_first2",  64'(o_first_err), 64'h008);
        chk("t3_nointr",  64'(o_intr), 64'd0);
        chk("t3_cnt",     64'(o_err_cnt), 64'd2);

        // error arriving in the recovery exit cycle
        i_afu_softreset = 1'b1; tick;
        i_afu_softreset = 1'b0; i_sw_clear = 1'b1; i_err_vec = 10'h004; tick;
        i_sw_clear = 1'b0; i_err_vec = '0;
        chk("tx_state",  64'(o_state), 64'd0);
        chk("tx_status", 64'(o_err_status), 64'h004);
        chk("tx_valid",  64'(o_err_valid), 64'd0);
        chk("tx_intr",   64'(o_intr), 64'd0);
        i_err_vec = 10'h020; tick;
        i_err_vec = '0;
        chk("tx_rearm",  64'(o_first_err), 64'h020);
        chk("tx_intr2",  64'(o_intr), 64'd1);
        chk("tx_status2", 64'(o_err_status), 64'h024);
        recover;
        chk("tx_recover", 64'(o_state), 64'd0);

        // 5: saturating counter over 300 error cycles
        i_err_vec = 10'h001;
        for (int i = 0; i < 254; i++) tick;
        chk("t5_cnt254", 64'(o_err_cnt), 64'd254);
        for (int i = 0; i < 46; i++) tick;
        i_err_vec = '0;
        chk("t5_cnt255", 64'(o_err_cnt), 64'd255);
        recover;

        // soft reset in IDLE with no error is ignored
        i_afu_softreset = 1'b1; tick;
        i_afu_softreset = 1'b0;
        chk("t6_sr_idle", 64'(o_state), 64'd0);

        // 6: error and clear together in IDLE -> error wins
        i_err_vec = 10'h200; i_sw_clear = 1'b1; i_err_vf_num = 11'h7ff; tick;
        i_err_vec = '0; i_sw_clear = 1'b0; i_err_vf_num = '0;
        chk("t6_first", 64'(o_first_err), 64'h200);
        chk("t6_valid", 64'(o_err_valid), 64'd1);
        chk("t6_vf",    64'(o_err_vf_num), 64'h7ff);
        chk("t6_state", 64'(o_state), 64'd2);
        recover;

        // error on the sop beat of a multi-beat packet, then async reset mid-DRAIN
        beat(1, 1, 0, 1); i_err_vec = 10'h040; tick;
        beat(1, 0, 0, 1); i_err_vec = '0;
        chk("t6_drain", 64'(o_state), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state",  64'(o_state), 64'd0);
        chk("ar_block",  64'(o_block_tx), 64'd0);
        chk("ar_drop",   64'(o_drop_tx), 64'd0);
        chk("ar_status", 64'(o_err_status), 64'd0);
        chk("ar_first",  64'(o_first_err), 64'd0);
        chk("ar_valid",  64'(o_err_valid), 64'd0);
        chk("ar_ts",     64'(o_err_ts), 64'd0);
        chk("ar_cnt",    64'(o_err_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/protocol_err_ctrl.md
Name: protocol_err_ctrl

Overview:
Error-response controller for the AFU TX protocol-checker datapath. It collects the per-error pulses from the protocol checker and captures first-error context (error, VF number, timestamp). It sequences the port through drain, block and recovery so that no further AFU TX traffic reaches the PCIe subsystem until software clears the error and the AFU soft reset completes. It sits between the protocol checker outputs, the port TX FIFO gate and the port error CSRs.

Parameters:
NUM_ERR, 10, number of error inputs; index map is fixed in the package.
TS_W, 32, width of the free-running timestamp counter.
CNT_W, 8, width of the saturating error-event counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_err_vec  in  NUM_ERR  single-cycle error pulses from the protocol checker; several bits may be set in one cycle
i_err_vf_num  in  11  VF number aligned with i_err_vec
i_tx_valid  in  1  AFU TX beat valid
i_tx_sop  in  1  AFU TX start of packet
i_tx_eop  in  1  AFU TX end of packet
i_tx_ready  in  1  AFU TX beat accepted
i_sw_clear  in  1  one-cycle CSR write-1 pulse to clear error state
i_afu_softreset  in  1  AFU soft reset, level
o_err_status  out  NUM_ERR  sticky OR of all errors seen since the last clear
o_first_err  out  NUM_ERR  one-hot first error; lowest index wins on a tie
o_err_vf_num  out  11  VF number captured with the first error
o_err_ts  out  TS_W  timestamp captured with the first error
o_err_cnt  out  CNT_W  saturating count of cycles with any error
o_err_valid  out  1  first-error context is valid
o_intr  out  1  one-cycle error interrupt pulse
o_block_tx  out  1  gate: suppress new AFU TX SOPs
o_drop_tx  out  1  discard the remaining beats of the in-flight packet
o_state  out  2  current FSM state, for CSR debug

Behaviour:
Reset values:
- All outputs are 0.
- FSM is IDLE.
- The timestamp counter, the in-packet flag and the clear-request flag are 0.

Timestamp:
- Free-running; increments every clk; wraps modulo 2^TS_W.

Packet tracker (an accepted beat means i_tx_valid & i_tx_ready):
- in_pkt sets on an accepted beat with sop & ~eop.
- in_pkt clears on an accepted beat with eop.
- A single-beat packet leaves in_pkt at 0.

Any error (any_err = |i_err_vec):
- o_err_status |= i_err_vec, registered with 1-cycle latency, in every state.
- o_err_cnt increments on any_err and saturates at all-ones.

IDLE:
- o_block_tx = 0 and o_drop_tx = 0.
- On any_err, the next cycle shows:
  - o_first_err = lowest set bit of i_err_vec;
  - o_err_vf_num and o_err_ts captured;
  - o_err_valid = 1;
  - o_intr = 1 for exactly one cycle.
- Next state: DRAIN if in_pkt (including the beat that sets it this cycle) and the current accepted beat is not eop; otherwise BLOCKED.
- i_sw_clear with no any_err: clears o_err_status, o_err_cnt and o_err_valid.
- any_err and i_sw_clear in the same cycle: the error wins and the clear is ignored.

DRAIN:
- o_block_tx = 1 and o_drop_tx = 1.
- On an accepted eop beat, go to BLOCKED next cycle.

BLOCKED:
- o_block_tx = 1 and o_drop_tx = 0.
- On i_afu_softreset = 1, go to WAIT_RST.

WAIT_RST:
- o_block_tx = 1.
- An i_sw_clear in BLOCKED or WAIT_RST sets clr_req.
- When i_afu_softreset = 0 and (clr_req or i_sw_clear), go to IDLE:
  - clear o_err_status, o_err_cnt, o_err_valid, o_first_err and clr_req;
  - o_block_tx drops in the same cycle the state becomes IDLE.
- An error arriving in the exit cycle is ORed into status after the clear, re-arms in IDLE on its next pulse only, and is not lost from o_err_status.

Later errors in DRAIN, BLOCKED or WAIT_RST:
- Update o_err_status and o_err_cnt only.
- o_first_err, o_err_vf_num and o_err_ts are held.
- No o_intr.

Soft reset in IDLE with no error: no state change.

o_state encoding: IDLE=0, DRAIN=1, BLOCKED=2, WAIT_RST=3.

Asynchronous reset mid-operation returns immediately to the reset values above.

Decomposition:
Package protocol_err_pkg holds:
- the err_state_e enum (2-bit);
- the error index constants: ERR_MALFORMED=0, ERR_MAX_PLD=1, ERR_MAX_RDREQ=2, ERR_MWR_INSUFF=3, ERR_MWR_OVERRUN=4, ERR_MMIO_INSUFF=5, ERR_MMIO_OVERRUN=6, ERR_MAX_TAG=7, ERR_MMIO_RD_RST=8, ERR_MMIO_WR_RST=9;
- NUM_ERR_DEFAULT;
- the first-one (lowest-bit) function.

One sub-module: tx_pkt_tracker, which produces in_pkt and the accepted-eop strobe.

Test Plan:
1. Idle, single-beat packets, i_err_vec=0x080 with vf 5 -> 1 cycle later: o_first_err=0x080, o_err_vf_num=5, o_intr pulse of width 1, state BLOCKED, o_block_tx=1.
2. Error during a 4-beat packet at beat 2 -> DRAIN with o_drop_tx=1 for beats 3-4; BLOCKED the cycle after the eop is accepted.
3. i_err_vec=0x018 simultaneously -> o_first_err=0x008, o_err_status=0x018; a later 0x001 pulse gives status=0x019, first_err unchanged, no second o_intr.
4. BLOCKED, i_sw_clear before soft reset, then soft reset high 10 cycles then low -> IDLE on the deassert cycle, all status cleared, o_block_tx=0.
5. 300 error pulses with CNT_W=8 -> o_err_cnt=255.
6. In IDLE, any_err and i_sw_clear in the same cycle -> error captured, state BLOCKED; rst_n low mid-DRAIN -> all outputs 0 asynchronously.
